// File: rtl/lstm_fixed_pkg.sv
// rtl/lstm_fixed_pkg.sv - shared Q4.4 fixed-point constants, MAC state enum and saturation helper
//
// Purpose : common definitions for the LSTM datapath (MAC neuron and activation stages).
// Contents: DATA_W/FRAC_W of the Q4.4 format, ONE (1.0 in Q4.4), mac_state_t,
//           sat_q() clipping a 32-bit signed value to a given signed width.
package lstm_fixed_pkg;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int ONE    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } mac_state_t;

  // Clip v to the signed range of a w-bit word; result stays 32 bits wide so
  // callers can tell a clip happened by comparing against the input.
  function automatic logic signed [31:0] sat_q(input logic signed [31:0] v,
                                                input int unsigned       w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/lstm_q_scale.sv
// rtl/lstm_q_scale.sv - combinational accumulator-to-Q4.4 shift, optional round, saturate
//
// Purpose : scale an ACC_W-bit sum (2*FRAC_W fractional bits) down to DATA_W bits.
// Macro   : LSTM_MAC_ROUND_EN - defined: round half up before the shift; undefined: floor.
// Ports   : i_acc   in  ACC_W  signed accumulator value
//           o_value out DATA_W signed saturated result
//           o_clip  out 1      result was clipped
module lstm_q_scale #(
  parameter int ACC_W  = 20,
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic signed [DATA_W-1:0] o_value,
  output logic                     o_clip
);
  import lstm_fixed_pkg::*;

  logic signed [31:0] w_ext;
  logic signed [31:0] w_shift;
  logic signed [31:0] w_sat;

  assign w_ext = 32'(i_acc);

`ifdef LSTM_MAC_ROUND_EN
  assign w_shift = (w_ext + (32'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
`else
  assign w_shift = w_ext >>> FRAC_W;
`endif

  assign w_sat   = sat_q(w_shift, DATA_W);
  assign o_value = w_sat[DATA_W-1:0];
  assign o_clip  = (w_sat != w_shift);

endmodule

// File: rtl/lstm_neuron_mac.sv
// rtl/lstm_neuron_mac.sv - serial multiply-accumulate neuron stage producing a Q4.4 pre-activation
//
// Purpose : acc = bias<<FRAC_W + sum(x*w) over N_INPUTS beats, then scale/saturate to Q4.4.
// Macro   : LSTM_MAC_ROUND_EN (inside lstm_q_scale) selects round-half-up instead of floor.
// Ports   : clk, rst (sync, active low)
//           start, bias           job start and its Q4.4 bias (sampled together)
//           in_valid/in_ready, x, w  operand beat handshake
//           z_valid/z_ready, z_value, sat  result handshake, value and clip flag
//           busy                  FSM not idle
module lstm_neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int FRAC_W   = 4,
  parameter int ACC_W    = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic                     z_valid,
  input  logic                     z_ready,
  output logic signed [DATA_W-1:0] z_value,
  output logic                     sat,
  output logic                     busy
);
  import lstm_fixed_pkg::*;

  localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  mac_state_t               r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [DATA_W-1:0] r_z_value;
  logic                     r_z_valid;
  logic                     r_sat;
  logic                     r_in_ready;
  logic                     r_busy;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [DATA_W-1:0]   w_scaled;
  logic                       w_clip;
  logic                       w_last;

  assign w_prod     = x * w;
  assign w_sum      = r_acc + ACC_W'(w_prod);
  // Bias is Q4.4; products are Q8.8, so align the bias to the product scale.
  assign w_bias_ext = ACC_W'(bias) <<< FRAC_W;
  assign w_last     = (r_cnt == CNT_W'(N_INPUTS - 1));

  // Scales the running sum including the current beat, so the result can be
  // registered on the final accepting edge.
  lstm_q_scale #(
    .ACC_W (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_scale (
    .i_acc  (w_sum),
    .o_value(w_scaled),
    .o_clip (w_clip)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_z_value  <= '0;
      r_z_valid  <= 1'b0;
      r_sat      <= 1'b0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc      <= w_bias_ext;
            r_cnt      <= '0;
            r_state    <= S_ACCUM;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_z_value  <= w_scaled;
              r_sat      <= w_clip;
              r_z_valid  <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (z_ready) begin
            r_z_valid <= 1'b0;
            if (start) begin
              // Back-to-back job: skip IDLE entirely.
              r_acc      <= w_bias_ext;
              r_cnt      <= '0;
              r_in_ready <= 1'b1;
              r_state    <= S_ACCUM;
            end else begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_z_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign z_valid  = r_z_valid;
  assign z_value  = r_z_value;
  assign sat      = r_sat;
  assign busy     = r_busy;

endmodule

// File: tb/tb_lstm_neuron_mac.sv
// tb/tb_lstm_neuron_mac.sv - directed self-checking bench for lstm_neuron_mac
module tb_lstm_neuron_mac;

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [7:0] bias;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x;
  logic signed [7:0] w;
  logic              z_valid;
  logic              z_ready;
  logic [7:0]        z_value;
  logic              sat;
  logic              busy;

  int n_cmp = 0;
  int n_bad = 0;

  lstm_neuron_mac #(
    .N_INPUTS(4),
    .DATA_W  (8),
    .FRAC_W  (4),
    .ACC_W   (20)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bias    (bias),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .x       (x),
    .w       (w),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .z_value (z_value),
    .sat     (sat),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] b);
    start = 1'b1;
    bias  = b;
    step();
    start = 1'b0;
    bias  = 8'sd0;
    check_eq("in_ready_after_start", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic beat(input logic [7:0] xv, input logic [7:0] wv);
    in_valid = 1'b1;
    x        = xv;
    w        = wv;
    step();
    in_valid = 1'b0;
    x        = 8'sd0;
    w        = 8'sd0;
  endtask

  task automatic finish_check(input string tag, input logic [7:0] exp_z, input logic exp_sat);
    check_eq({tag, "_z_valid"}, {31'b0, z_valid}, 32'd1);
    check_eq({tag, "_z_value"}, {24'b0, z_value}, {24'b0, exp_z});
    check_eq({tag, "_sat"},     {31'b0, sat},     {31'b0, exp_sat});
    check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    z_ready = 1'b1;
    step();
    z_ready = 1'b0;
    check_eq({tag, "_z_valid_drop"}, {31'b0, z_valid}, 32'd0);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  // Four identical beats; optional stall cycle after the first beat.
  task automatic run_uniform(input string tag, input logic [7:0] b, input logic [7:0] xv,
                             input logic [7:0] wv, input logic [7:0] exp_z, input logic exp_sat,
                             input bit gap);
    start_job(b);
    for (int i = 0; i < 4; i++) begin
      beat(xv, wv);
      if (gap && i == 0) begin
        x = 8'sd99;
        w = 8'sd99;
        step();
        check_eq({tag, "_stall_in_ready"}, {31'b0, in_ready}, 32'd1);
      end
      if (i < 3) check_eq({tag, "_early_z_valid"}, {31'b0, z_valid}, 32'd0);
    end
    finish_check(tag, exp_z, exp_sat);
  endtask

  logic [7:0] exp_rnd_pos;
  logic [7:0] held_z;

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    bias     = 8'sd0;
    in_valid = 1'b0;
    x        = 8'sd0;
    w        = 8'sd0;
    z_ready  = 1'b0;
    step();
    step();
    check_eq("rst_z_value",  {24'b0, z_value}, 32'd0);
    check_eq("rst_z_valid",  {31'b0, z_valid}, 32'd0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_busy",     {31'b0, busy}, 32'd0);
    check_eq("rst_sat",      {31'b0, sat}, 32'd0);
    rst = 1'b1;

    // in_valid in IDLE is ignored.
    in_valid = 1'b1;
    x        = 8'sd16;
    w        = 8'sd16;
    step();
    in_valid = 1'b0;
    check_eq("idle_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("idle_busy",     {31'b0, busy}, 32'd0);

    // 4 * 256 = 1024 (Q8.8) -> 64 (Q4.4)
    run_uniform("basic", 8'sd0, 8'sd16, 8'sd16, 8'd64, 1'b0, 1'b0);
    run_uniform("stall", 8'sd0, 8'sd16, 8'sd16, 8'd64, 1'b0, 1'b1);
    // 4 * 16129 = 64516 -> 4032 -> clip 127
    run_uniform("sat_pos", 8'sd0, 8'sd127, 8'sd127, 8'd127, 1'b1, 1'b0);
    // 4 * -16256 = -65024 -> -4064 -> clip -128
    run_uniform("sat_neg", 8'sd0, -8'sd128, 8'sd127, 8'h80, 1'b1, 1'b0);
`ifdef LSTM_MAC_ROUND_EN
    exp_rnd_pos = 8'd1;
`else
    exp_rnd_pos = 8'd0;
`endif
    // 12 -> floor 0 / round 1 ; -12 -> -1 in both builds
    run_uniform("round_pos", 8'sd0, 8'sd1, 8'sd3, exp_rnd_pos, 1'b0, 1'b0);
    run_uniform("round_neg", 8'sd0, -8'sd1, 8'sd3, 8'hFF, 1'b0, 1'b0);
    // bias -16 (=-1.0) plus 4*(0.5*1.0): 128*? -> (-256 + 4*128) = 256 -> 16
    run_uniform("neg_bias", -8'sd16, 8'sd8, 8'sd16, 8'd16, 1'b0, 1'b0);

    // Backpressure: result 64 held while z_ready low, start/in_valid ignored.
    start_job(8'sd0);
    for (int i = 0; i < 4; i++) beat(8'sd16, 8'sd16);
    held_z = 8'd64;
    for (int i = 0; i < 10; i++) begin
      start    = i[0];
      in_valid = ~i[0];
      x        = 8'sd5;
      w        = 8'sd5;
      step();
      check_eq("bp_z_value",  {24'b0, z_value}, {24'b0, held_z});
      check_eq("bp_z_valid",  {31'b0, z_valid}, 32'd1);
      check_eq("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    // Accept result and start the next job on the same edge.
    z_ready = 1'b1;
    start   = 1'b1;
    bias    = 8'sd8;
    step();
    z_ready = 1'b0;
    start   = 1'b0;
    bias    = 8'sd0;
    check_eq("b2b_in_ready", {31'b0, in_ready}, 32'd1);
    check_eq("b2b_z_valid",  {31'b0, z_valid}, 32'd0);
    check_eq("b2b_busy",     {31'b0, busy}, 32'd1);
    // bias 8 -> 128, + 16*8 = 256 -> 16
    beat(8'sd16, 8'sd8);
    beat(8'sd0, 8'sd0);
    beat(8'sd0, 8'sd0);
    beat(8'sd0, 8'sd0);
    finish_check("bias_b2b", 8'd16, 1'b0);

    // Reset after two of four beats discards the partial sum.
    start_job(8'sd0);
    beat(8'sd16, 8'sd16);
    beat(8'sd16, 8'sd16);
    rst = 1'b0;
    step();
    check_eq("mid_rst_z_value",  {24'b0, z_value}, 32'd0);
    check_eq("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("mid_rst_busy",     {31'b0, busy}, 32'd0);
    check_eq("mid_rst_z_valid",  {31'b0, z_valid}, 32'd0);
    check_eq("mid_rst_sat",      {31'b0, sat}, 32'd0);
    rst = 1'b1;
    run_uniform("post_rst", 8'sd0, 8'sd16, 8'sd16, 8'd64, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
